// File: rtl/lfsr_pkg.sv
// Shared constants, enums and helper functions for the LFSR random number generator.
package lfsr_pkg;

    localparam logic [31:0] TAP_W8  = 32'h0000_00B8;
    localparam logic [31:0] TAP_W16 = 32'h0000_B400;
    localparam logic [31:0] TAP_W32 = 32'h8020_0003;

    typedef enum logic [1:0] {
        MODE_RAW   = 2'd0,
        MODE_INT   = 2'd1,
        MODE_RANGE = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    typedef enum logic {
        ST_GEN = 1'b0,
        ST_OUT = 1'b1
    } fsm_e;

    function automatic logic [31:0] tap_for_width(input int width);
        logic [31:0] tap;
        case (width)
            32'sd8:  tap = TAP_W8;
            32'sd16: tap = TAP_W16;
            32'sd32: tap = TAP_W32;
            default: tap = TAP_W8;
        endcase
        return tap;
    endfunction

    // Smallest all-ones value 2^k-1 that is not below the bound (0 for a zero bound).
    function automatic logic [31:0] mask_from_bound(input logic [31:0] bound);
        logic [31:0] mask;
        mask = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (mask < bound) begin
                mask = {mask[30:0], 1'b1};
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// Pure combinational right-shifting Galois LFSR step.
module lfsr_core #(
    parameter int                   S_WIDTH = 8,
    parameter logic [S_WIDTH-1:0]   TAP     = {S_WIDTH{1'b0}}
) (
    input  logic [S_WIDTH-1:0] i_state,
    output logic [S_WIDTH-1:0] o_next
);

    assign o_next = (i_state >> 1) ^ (i_state[0] ? TAP : {S_WIDTH{1'b0}});

endmodule

// File: rtl/lfsr_rng_gen_chk.sv
// Protocol checks for lfsr_rng_gen: sample hold under back-pressure and LFSR liveness.
module lfsr_rng_gen_chk #(
    parameter int S_WIDTH = 8
) (
    input logic               clk_i,
    input logic               rst_i,
    input logic               seed_valid_i,
    input logic               rand_ready_i,
    input logic               rand_valid_o,
    input logic               fallback_o,
    input logic [S_WIDTH-1:0] rand_o,
    input logic [S_WIDTH-1:0] lfsr_state
);

    a_hold_stable: assert property (@(posedge clk_i) disable iff (!rst_i)
        (rand_valid_o && !rand_ready_i && !seed_valid_i)
        |=> (rand_valid_o && $stable(rand_o) && $stable(fallback_o)));

    a_no_lockup: assert property (@(posedge clk_i) disable iff (!rst_i)
        lfsr_state != {S_WIDTH{1'b0}});

    a_fallback_valid: assert property (@(posedge clk_i) disable iff (!rst_i)
        fallback_o |-> rand_valid_o);

endmodule

// File: rtl/lfsr_rng_gen.sv
// Galois-LFSR random number generator with raw, low-bit and bounded-range
// sampling, rejection with fallback, and a valid/ready output handshake.
module lfsr_rng_gen
    import lfsr_pkg::*;
#(
    parameter int          S_WIDTH      = 8,
    parameter int          INT_WIDTH    = 2,
    parameter logic [31:0] SEED_DEFAULT = 32'd1,
    parameter int          MAX_TRIES    = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               seed_valid_i,
    input  logic [S_WIDTH-1:0] seed_i,
    input  logic [1:0]         mode_i,
    input  logic [S_WIDTH-1:0] bound_i,
    input  logic               rand_ready_i,
    output logic               rand_valid_o,
    output logic [S_WIDTH-1:0] rand_o,
    output logic               fallback_o
);

    localparam logic [S_WIDTH-1:0] TAP      = S_WIDTH'(tap_for_width(S_WIDTH));
    localparam logic [S_WIDTH-1:0] SEED     = S_WIDTH'(SEED_DEFAULT);
    localparam logic [S_WIDTH-1:0] INT_MASK = S_WIDTH'((64'd1 << INT_WIDTH) - 64'd1);
    localparam int                 TRY_W    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [TRY_W-1:0]   TRY_LAST = TRY_W'(MAX_TRIES - 1);
    localparam logic [S_WIDTH-1:0] ZERO     = {S_WIDTH{1'b0}};

    logic [S_WIDTH-1:0] r_state;
    fsm_e               r_fsm;
    logic               r_valid;
    logic [S_WIDTH-1:0] r_rand;
    logic               r_fallback;
    logic [TRY_W-1:0]   r_tries;
    logic               r_armed;

    logic [S_WIDTH-1:0] w_next;
    logic [S_WIDTH-1:0] w_mask;
    logic [S_WIDTH-1:0] w_cand;
    logic [S_WIDTH-1:0] w_sample;
    logic               w_accept;
    logic               w_fb;
    logic               w_step;
    mode_e              w_mode;

    lfsr_core #(
        .S_WIDTH (S_WIDTH),
        .TAP     (TAP)
    ) u_core (
        .i_state (r_state),
        .o_next  (w_next)
    );

    assign w_mode = mode_e'(mode_i);
    assign w_mask = S_WIDTH'(mask_from_bound(32'(bound_i)));
    assign w_step = (r_fsm == ST_GEN) || (r_valid && rand_ready_i);

    // Candidate evaluation for the value the LFSR steps to this cycle.
    always_comb begin
        w_cand   = w_next;
        w_sample = w_next;
        w_accept = 1'b1;
        w_fb     = 1'b0;
        case (w_mode)
            MODE_INT: begin
                w_sample = w_next & INT_MASK;
            end
            MODE_RANGE: begin
                w_cand = w_next & w_mask;
                if (w_cand <= bound_i) begin
                    w_sample = w_cand;
                end else if (r_tries == TRY_LAST) begin
                    // Out of tries: fold the last rejected candidate into range.
                    w_sample = w_cand - (bound_i + {{(S_WIDTH-1){1'b0}}, 1'b1});
                    w_fb     = 1'b1;
                end else begin
                    w_sample = w_cand;
                    w_accept = 1'b0;
                end
            end
            default: begin
                w_sample = w_next;
            end
        endcase
    end

    // GEN/OUT sequencer; seed load outranks stepping, and the first cycle after
    // reset release only arms the generator.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= SEED;
            r_fsm      <= ST_GEN;
            r_valid    <= 1'b0;
            r_rand     <= ZERO;
            r_fallback <= 1'b0;
            r_tries    <= {TRY_W{1'b0}};
            r_armed    <= 1'b0;
        end else if (seed_valid_i) begin
            r_state    <= (seed_i == ZERO) ? SEED : seed_i;
            r_fsm      <= ST_GEN;
            r_valid    <= 1'b0;
            r_fallback <= 1'b0;
            r_tries    <= {TRY_W{1'b0}};
            r_armed    <= 1'b1;
        end else if (r_state == ZERO) begin
            r_state <= SEED;
        end else if (!r_armed) begin
            r_armed <= 1'b1;
        end else if (w_step) begin
            r_state <= w_next;
            if (w_accept) begin
                r_rand     <= w_sample;
                r_fallback <= w_fb;
                r_valid    <= 1'b1;
                r_fsm      <= ST_OUT;
                r_tries    <= {TRY_W{1'b0}};
            end else begin
                r_fallback <= 1'b0;
                r_valid    <= 1'b0;
                r_fsm      <= ST_GEN;
                r_tries    <= r_tries + TRY_W'(1'b1);
            end
        end
    end

    assign rand_valid_o = r_valid;
    assign rand_o       = r_rand;
    assign fallback_o   = r_fallback;

    lfsr_rng_gen_chk #(
        .S_WIDTH (S_WIDTH)
    ) u_chk (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .seed_valid_i (seed_valid_i),
        .rand_ready_i (rand_ready_i),
        .rand_valid_o (r_valid),
        .fallback_o   (r_fallback),
        .rand_o       (r_rand),
        .lfsr_state   (r_state)
    );

endmodule
